// File: rtl/cipher_pkg.sv
// Shared types and constants for the bit-serial cipher arbiter.
// Imported by the interface, core and arbiter.
package cipher_pkg;

  localparam int KEY_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_e;

endpackage

// File: rtl/cipher_arbiter_if.sv
// Requester/consumer bundle for the cipher arbiter.
// master drives jobs and consumes results; slave is the arbiter.
interface cipher_arbiter_if
  import cipher_pkg::*;
#(
  parameter int N = 16
);

  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic [KEY_W-1:0] req0_key;
  logic [KEY_W-1:0] req1_key;
  logic [N-1:0]     req0_plaintext;
  logic [N-1:0]     req1_plaintext;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [N-1:0]     resp_ciphertext;
  logic             busy;

  modport master (
    output req0_valid, req1_valid,
    output req0_key, req1_key,
    output req0_plaintext, req1_plaintext,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id,
    input  resp_ciphertext, busy
  );

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_key, req1_key,
    input  req0_plaintext, req1_plaintext,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id,
    output resp_ciphertext, busy
  );

endinterface

// File: rtl/cipher_serial_core.sv
// Bit-serial XOR datapath: one ciphertext bit per step,
// ct[i] = pt[i] ^ key[i mod KEY_W], LSB first.
module cipher_serial_core
  import cipher_pkg::*;
#(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic [N-1:0]     pt_i,
  output logic             done_o,
  output logic [N-1:0]     ct_o
);

  localparam int CW = $clog2(N) + 1;
  localparam int IW = $clog2(N);
  localparam int KW = $clog2(KEY_W);

  logic [KEY_W-1:0] key_q, key_d;
  logic [N-1:0]     pt_q, pt_d;
  logic [N-1:0]     ct_q, ct_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    pidx;
  logic [KW-1:0]    kidx;

  assign pidx   = cnt_q[IW-1:0];
  assign kidx   = KW'(cnt_q);
  assign done_o = (cnt_q == CW'(N));
  assign ct_o   = ct_q;

  always_comb begin
    key_d = key_q;
    pt_d  = pt_q;
    ct_d  = ct_q;
    cnt_d = cnt_q;
    if (load_i) begin
      key_d = key_i;
      pt_d  = pt_i;
      ct_d  = '0;
      cnt_d = '0;
    end else if (step_i && !done_o) begin
      ct_d[pidx] = pt_q[pidx] ^ key_q[kidx];
      cnt_d      = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
      pt_q  <= '0;
      ct_q  <= '0;
      cnt_q <= '0;
    end else begin
      key_q <= key_d;
      pt_q  <= pt_d;
      ct_q  <= ct_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cipher_arbiter.sv
// Two-requester round-robin front end sharing one
// bit-serial cipher core, with a held response slot.
module cipher_arbiter
  import cipher_pkg::*;
#(
  parameter int N = 16
) (
  input logic             clk,
  input logic             rst,
  cipher_arbiter_if.slave bus
);

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   id_q, id_d;
  logic   pick1;
  logic   rdy0, rdy1;
  logic   load, step, done;

  logic [KEY_W-1:0] sel_key;
  logic [N-1:0]     sel_pt;
  logic [N-1:0]     ct;

  // Sole valid requester wins; otherwise the one not granted last.
  assign pick1 = (bus.req1_valid & ~bus.req0_valid)
               | (~(bus.req0_valid ^ bus.req1_valid) & ~last_q);

  always_comb begin
    sel_key = bus.req0_key;
    sel_pt  = bus.req0_plaintext;
    unique case (1'b1)
      pick1: begin
        sel_key = bus.req1_key;
        sel_pt  = bus.req1_plaintext;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy0 = ~pick1;
        rdy1 = pick1;
        if ((rdy0 & bus.req0_valid) | (rdy1 & bus.req1_valid)) begin
          load    = 1'b1;
          id_d    = pick1;
          last_d  = pick1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (done) state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
    end
  end

  cipher_serial_core #(.N(N)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .step_i (step),
    .key_i  (sel_key),
    .pt_i   (sel_pt),
    .done_o (done),
    .ct_o   (ct)
  );

  assign bus.req0_ready      = rdy0;
  assign bus.req1_ready      = rdy1;
  assign bus.resp_valid      = (state_q == RESP);
  assign bus.resp_id         = id_q;
  assign bus.resp_ciphertext = ct;
  assign bus.busy            = (state_q != IDLE);

endmodule
